fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Decoupling buffer between the fetch stage (PC register plus instruction memory) and the decode stage of the 16-bit pipelined core.
- Captures {PC, instruction, redirect tag} each fetch cycle into a small first-word-fall-through (FWFT) FIFO.
- Presents the head entry to decode under a valid/ready handshake.
- Drives the stall input of the PC register.
- A redirect flush from writeback discards all queued wrong-path instructions.

Parameters:
PC_W, 16, width of program counter.
INSTR_W, 32, width of an instruction word.
DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
clk  input  1  clock.
reset  input  1  reset, asynchronous, active-high.
f_valid  input  1  fetch presents a valid instruction this cycle.
f_pc  input  PC_W  PC of the fetched instruction (PC register output).
f_instr  input  INSTR_W  fetched instruction word.
f_redir  input  1  redirect tag from the PC register (PCSrc fetch-to-decode bit).
f_stall  output  1  stall to the PC register; high when the queue cannot accept.
flush  input  1  redirect from writeback; discard all entries.
d_ready  input  1  decode can consume the head entry this cycle.
d_valid  output  1  head entry valid.
d_pc  output  PC_W  head PC.
d_pc_plus1  output  PC_W  head PC + 1, modulo 2^PC_W.
d_instr  output  INSTR_W  head instruction.
d_redir  output  1  head redirect tag.
count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries; write pointer, read pointer and count are registers. Pointers wrap from DEPTH-1 to 0.
- Reset (async): pointers = 0, count = 0, d_valid = 0, f_stall = 0. Entry contents are don't-care, but d_pc, d_instr, d_redir and d_pc_plus1 must not be X when d_valid = 0; the head data registers also clear to 0.
- f_stall = (count == DEPTH). It depends on registered count only, with no combinational path from d_ready.
- Push: f_valid && !f_stall. Writes {f_pc, f_instr, f_redir} at the write pointer; write pointer increments.
- Pop: d_valid && d_ready. Read pointer increments.
- d_valid = (count != 0). Outputs reflect the read-pointer entry combinationally (FWFT).
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 when the queue was empty.
- Simultaneous push and pop: count unchanged; both pointers advance. Legal at any occupancy where push is allowed.
- Full: f_valid is ignored and nothing is written. The fetch side holds its values because f_stall stops the PC register. A pop while full lowers f_stall the next cycle.
- Empty: d_ready is ignored and no pop occurs.
- Flush: synchronous, highest priority. Next cycle pointers = 0, count = 0, d_valid = 0. A same-cycle push and pop are both discarded.
- d_pc_plus1 = d_pc + 1, truncated to PC_W bits, so 16'hFFFF gives 16'h0000.
- count never exceeds DEPTH and never underflows. The bench checks both with assertions.
- Reset asserted mid-operation clears all state immediately. The first push after reset deassertion is accepted normally.

Optional Feature:
Macro FETCHQ_BYPASS_EN.
- Defined: when count == 0, f_valid = 1 and flush = 0, the f_* inputs drive the d_* outputs combinationally and d_valid = 1 that cycle.
  - If d_ready = 1, the instruction is consumed and not written; count stays 0.
  - If d_ready = 0, the instruction is written normally.
  - Empty-queue latency becomes 0 cycles.
- Not defined: no bypass path; minimum latency is 1 cycle. All other behaviour is identical.

Test Plan:
1. Reset, then push PC 0x0010..0x0013 with d_ready = 0 -> count = 4, f_stall = 1 in the cycle after the 4th push; a 5th f_valid with PC 0x0014 is not stored.
2. Continue from test 1 with d_ready = 1 for 4 cycles -> d_pc sequence 0x0010, 0x0011, 0x0012, 0x0013; f_stall falls the cycle after the first pop; d_valid = 0 after the last pop.
3. Continuous push and pop with count = 2 for 10 cycles -> count stays 2, order preserved, pointers wrap with no lost or duplicated PC.
4. Queue holding 3 entries; flush = 1 in the same cycle as f_valid (PC 0x0040) and d_ready -> next cycle count = 0, d_valid = 0; the following push of PC 0x0050 with f_redir = 1 appears at the head with d_redir = 1.
5. Push f_pc = 16'hFFFF -> d_pc_plus1 = 16'h0000.
6. Assert reset mid-stream with count = 3 -> d_valid = 0, f_stall = 0, count = 0 immediately. With FETCHQ_BYPASS_EN defined, an empty queue with f_valid and d_ready and PC 0x0100 -> d_valid = 1 and d_pc = 0x0100 in the same cycle, count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode FWFT queue: buffers {pc, instr, redir}, stalls the PC register when full.
// Optional zero-latency empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_valid,
  input  logic [PC_W-1:0]          f_pc,
  input  logic [INSTR_W-1:0]       f_instr,
  input  logic                     f_redir,
  output logic                     f_stall,
  input  logic                     flush,
  input  logic                     d_ready,
  output logic                     d_valid,
  output logic [PC_W-1:0]          d_pc,
  output logic [PC_W-1:0]          d_pc_plus1,
  output logic [INSTR_W-1:0]       d_instr,
  output logic                     d_redir,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               redir;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            empty;

  assign empty   = (count == '0);
  assign f_stall = (count == CW'(DEPTH));
  assign pop     = !empty && d_ready && !flush;

`ifdef FETCHQ_BYPASS_EN
  logic byp;
  assign byp  = empty && f_valid && !flush;
  assign push = f_valid && !f_stall && !flush && !(byp && d_ready);
`else
  assign push = f_valid && !f_stall && !flush;
`endif

  // Head selection: stored read-pointer entry, or the live fetch word on bypass.
  always_comb begin
    head    = mem[rd_ptr];
    d_valid = !empty;
`ifdef FETCHQ_BYPASS_EN
    if (byp) begin
      head    = '{pc: f_pc, instr: f_instr, redir: f_redir};
      d_valid = 1'b1;
    end
`endif
  end

  assign d_pc       = head.pc;
  assign d_pc_plus1 = head.pc + PC_W'(1);
  assign d_instr    = head.instr;
  assign d_redir    = head.redir;

  // Entry storage; cleared on reset so the head never shows X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{pc: f_pc, instr: f_instr, redir: f_redir};
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 0;
  logic        reset;
  logic        f_valid;
  logic [15:0] f_pc;
  logic [31:0] f_instr;
  logic        f_redir;
  logic        f_stall;
  logic        flush;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_pc;
  logic [15:0] d_pc_plus1;
  logic [31:0] d_instr;
  logic        d_redir;
  logic [2:0]  count;

  fetch_queue #(.PC_W(16), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .f_redir(f_redir), .f_stall(f_stall), .flush(flush),
    .d_ready(d_ready), .d_valid(d_valid), .d_pc(d_pc),
    .d_pc_plus1(d_pc_plus1), .d_instr(d_instr),
    .d_redir(d_redir), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        redir;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Occupancy must stay within 0..DEPTH (unsigned underflow would show as > DEPTH).
  always @(negedge clk) begin
    if (!reset) begin
      n_chk++;
      if (int'(count) > DEPTH) begin
        n_fail++;
        $display("FAIL count_bound: got %0d limit %0d", count, DEPTH);
      end
    end
  end

  // One cycle: drive, compare against the model, clock, advance the model.
  task automatic step(input logic fv, input logic [15:0] pc,
                      input logic rd, input logic fl, input logic rdy);
    logic  byp, edv, do_pop, do_push;
    ent_t  e;
    logic [31:0] ins;
    logic [15:0] ep1;
    ins = {16'hC0DE, pc};
    @(negedge clk);
    f_valid = fv; f_pc = pc; f_instr = ins; f_redir = rd;
    flush = fl; d_ready = rdy;
    #1;
    byp = BYP && (q.size() == 0) && fv && !fl;
    edv = (q.size() != 0) || byp;
    chk("count", 64'(count), 64'(q.size()));
    chk("f_stall", 64'(f_stall), 64'(q.size() == DEPTH));
    chk("d_valid", 64'(d_valid), 64'(edv));
    if (edv) begin
      if (byp) e = '{pc: pc, instr: ins, redir: rd};
      else     e = q[0];
      ep1 = e.pc + 16'd1;
      chk("d_pc", 64'(d_pc), 64'(e.pc));
      chk("d_instr", 64'(d_instr), 64'(e.instr));
      chk("d_redir", 64'(d_redir), 64'(e.redir));
      chk("d_pc_plus1", 64'(d_pc_plus1), 64'(ep1));
    end else begin
      chk("d_known", 64'($isunknown({d_pc, d_instr, d_redir, d_pc_plus1})), 64'(0));
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else if (!(byp && rdy)) begin
      do_pop  = (q.size() != 0) && rdy;
      do_push = fv && (q.size() < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: pc, instr: ins, redir: rd});
    end
  endtask

  task automatic do_reset();
    f_valid = 0; f_pc = 0; f_instr = 0; f_redir = 0;
    flush = 0; d_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    q.delete();
  endtask

  typedef struct {
    logic        fv;
    logic [15:0] pc;
    logic        rdy;
    int          ecnt;
    logic        estall;
    logic        edv;
    logic [15:0] epc;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{1'b1, 16'h0010, 1'b0, 0, 1'b0, BYP,  16'h0010};
    tv[1] = '{1'b1, 16'h0011, 1'b0, 1, 1'b0, 1'b1, 16'h0010};
    tv[2] = '{1'b1, 16'h0012, 1'b0, 2, 1'b0, 1'b1, 16'h0010};
    tv[3] = '{1'b1, 16'h0013, 1'b0, 3, 1'b0, 1'b1, 16'h0010};
    tv[4] = '{1'b1, 16'h0014, 1'b0, 4, 1'b1, 1'b1, 16'h0010};
    tv[5] = '{1'b1, 16'h0014, 1'b1, 4, 1'b1, 1'b1, 16'h0010};
    tv[6] = '{1'b0, 16'h0000, 1'b1, 3, 1'b0, 1'b1, 16'h0011};
    tv[7] = '{1'b0, 16'h0000, 1'b1, 2, 1'b0, 1'b1, 16'h0012};
    tv[8] = '{1'b0, 16'h0000, 1'b1, 1, 1'b0, 1'b1, 16'h0013};
    tv[9] = '{1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 16'h0000};

    do_reset();
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_stall", 64'(f_stall), 64'(0));
    chk("rst_dvalid", 64'(d_valid), 64'(0));
    chk("rst_dpc", 64'(d_pc), 64'(0));

    // Fill to full, overflow attempt, then drain in order.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f_valid = tv[i].fv; f_pc = tv[i].pc;
      f_instr = {16'hA5A5, tv[i].pc}; f_redir = 0;
      flush = 0; d_ready = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d_count", i), 64'(count), 64'(tv[i].ecnt));
      chk($sformatf("tv%0d_stall", i), 64'(f_stall), 64'(tv[i].estall));
      chk($sformatf("tv%0d_dvalid", i), 64'(d_valid), 64'(tv[i].edv));
      if (tv[i].edv) begin
        chk($sformatf("tv%0d_dpc", i), 64'(d_pc), 64'(tv[i].epc));
        chk($sformatf("tv%0d_dinstr", i), 64'(d_instr),
            64'({16'hA5A5, tv[i].epc}));
      end
    end

    // Steady push+pop at occupancy 2 across pointer wrap.
    do_reset();
    step(1, 16'h0020, 0, 0, 0);
    step(1, 16'h0021, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 16'h0022 + 16'(i), 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("pp_count", 64'(count), 64'(2));
    chk("pp_head", 64'(d_pc), 64'(16'h002A));

    // Flush with 3 entries, concurrent push and pop discarded.
    step(1, 16'h0030, 0, 0, 0);
    step(1, 16'h0040, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(1, 16'h0050, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("fl_head_pc", 64'(d_pc), 64'(16'h0050));
    chk("fl_head_redir", 64'(d_redir), 64'(1));
    step(0, 0, 0, 0, 1);

    // PC wrap on pc+1.
    step(1, 16'hFFFF, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pc_wrap", 64'(d_pc_plus1), 64'(16'h0000));
    step(0, 0, 0, 0, 1);

    // Asynchronous reset mid-stream with 3 entries.
    step(1, 16'h0060, 0, 0, 0);
    step(1, 16'h0061, 0, 0, 0);
    step(1, 16'h0062, 0, 0, 0);
    @(negedge clk);
    f_valid = 0; d_ready = 0; flush = 0;
    #2 reset = 1;
    #1;
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_dvalid", 64'(d_valid), 64'(0));
    chk("arst_stall", 64'(f_stall), 64'(0));
    q.delete();
    @(negedge clk);
    reset = 0;
    step(1, 16'h0070, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

`ifdef FETCHQ_BYPASS_EN
    // Empty queue with a ready consumer: same-cycle delivery, nothing stored.
    step(1, 16'h0100, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("byp_count", 64'(count), 64'(0));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), 1'($urandom),
           ($urandom % 20) == 0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
